// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: resets and runs a CPU for a bounded burst, then streams a snapshot of its register file.
// A continuous session repeats run+scan phases until stop is seen.
module reg_dump_ctrl #(
  parameter int DATA_W = 32,
  parameter int NREG = 32,
  parameter int RST_CYCLES = 2,
  parameter int RUN_CYCLES = 10,
  localparam int SEL_W = NREG > 1 ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode_cont,
  input  logic              stop,
  input  logic              halt,
  output logic              cpu_rstn,
  output logic              cpu_en,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [SEL_W-1:0]  dump_idx,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);
  localparam logic [2:0] IDLE = 3'd0, RESET = 3'd1, RUN = 3'd2, SCAN = 3'd3, DONE = 3'd4;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NREG - 1);
  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] RUN_LAST = 32'(RUN_CYCLES - 1);
  logic [2:0] state, state_nxt;
  logic [31:0] cnt;
  logic settle, mode, stop_seen, cap, fin, run_end, rst_end, step;
  assign cpu_en = state == RUN;
  assign busy = state == RESET || state == RUN || state == SCAN;
  always_comb begin
    run_end = cpu_en && (halt || cnt == RUN_LAST);
    rst_end = state == RESET && cnt == RST_LAST;
    // once the last beat is captured, nothing more is captured until it is accepted
    cap = state == SCAN && settle && (!dump_valid || dump_ready) && !(dump_valid && dump_last);
    fin = state == SCAN && dump_valid && dump_ready && dump_last;
    step = cap && reg_sel != SEL_LAST;
    state_nxt = state == IDLE ? (start ? RESET : IDLE) :
                rst_end ? RUN :
                run_end ? SCAN :
                fin ? ((!mode || stop_seen || stop) ? DONE : RUN) :
                state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      cpu_rstn <= 1'b0;
      reg_sel <= '0;
      settle <= 1'b0;
      mode <= 1'b0;
      stop_seen <= 1'b0;
      done <= 1'b0;
      dump_valid <= 1'b0;
      dump_data <= '0;
      dump_idx <= '0;
      dump_last <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state_nxt == state ? cnt + 32'd1 : '0;
      cpu_rstn <= state_nxt != RESET;
      reg_sel <= run_end ? '0 : step ? reg_sel + 1'b1 : reg_sel;
      settle <= state == SCAN && !step;
      if (state == IDLE && start) mode <= mode_cont;
      stop_seen <= state_nxt != IDLE && (stop_seen || (busy && stop));
      done <= state_nxt == DONE || (done && !(state == IDLE && start));
      if (cap) begin
        dump_valid <= 1'b1;
        dump_data <= reg_data;
        dump_idx <= reg_sel;
        dump_last <= reg_sel == SEL_LAST;
      end else if (dump_ready) dump_valid <= 1'b0;
    end
endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of the observed register data.
REQ-002 Parameter NREG, default 32, number of registers scanned (indices 0..NREG-1); SEL_W = clog2(NREG), minimum 1.
REQ-003 Parameter RST_CYCLES, default 2, number of cycles the CPU reset is held low (minimum 1).
REQ-004 Parameter RUN_CYCLES, default 10, number of cycles the CPU runs per run phase (minimum 1).
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 rstn  in  1  reset; asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a session; honoured only in IDLE.
REQ-008 mode_cont  in  1  sampled with start; 1 = continuous snapshots, 0 = single shot.
REQ-009 stop  in  1  ends a continuous session after the current scan completes.
REQ-010 halt  in  1  CPU halted indication; ends the run phase early.
REQ-011 cpu_rstn  out  1  active-low reset driven to the CPU.
REQ-012 cpu_en  out  1  CPU clock enable; 1 only in RUN.
REQ-013 reg_sel  out  SEL_W  register index presented to the CPU.
REQ-014 reg_data  in  DATA_W  CPU register file read data for reg_sel (combinational in the CPU).
REQ-015 dump_valid / dump_ready  out / in  1 / 1  output stream handshake.
REQ-016 dump_data  out  DATA_W  captured register value.
REQ-017 dump_idx  out  SEL_W  index of dump_data.
REQ-018 dump_last  out  1  marks the beat with dump_idx = NREG-1.
REQ-019 busy / done  out / out  1 / 1  session active; single-shot session complete (sticky).

Function
REQ-020 The FSM SHALL have states IDLE, RESET, RUN, SCAN, DONE.
REQ-021 IDLE: cpu_rstn=1, cpu_en=0, busy=0; start=1 SHALL latch mode_cont, clear done, and enter RESET on the next edge.
REQ-022 RESET: cpu_rstn=0 for exactly RST_CYCLES cycles, then RUN.
REQ-023 RUN: cpu_rstn=1, cpu_en=1; SHALL leave after RUN_CYCLES cycles or on the first cycle halt=1, whichever comes first, and enter SCAN with reg_sel=0.
REQ-024 SCAN: cpu_en=0; a settle flag SHALL be cleared whenever reg_sel changes and set one cycle later.
REQ-025 Capture SHALL occur on an edge where state=SCAN, settle=1, and (dump_valid=0 or dump_ready=1): dump_data<=reg_data, dump_idx<=reg_sel, dump_last<=(reg_sel==NREG-1), dump_valid<=1, reg_sel incremented unless it equals NREG-1.
REQ-026 The minimum interval between captures SHALL be 2 cycles per register.
REQ-027 dump_valid SHALL remain 1 and dump_data/idx/last stable until a cycle with dump_ready=1; dump_valid falls on an accepting edge with no new capture.
REQ-028 After the dump_last beat is accepted: single shot, or continuous with stop seen since the session started, SHALL go to DONE; otherwise it SHALL go to RUN (no CPU reset) with a fresh RUN_CYCLES count.
REQ-029 stop SHALL be latched in RESET, RUN, or SCAN and cleared on entry to IDLE.
REQ-030 DONE: done=1, busy=0, cpu_en=0; SHALL return to IDLE next cycle; done SHALL stay 1 until the next accepted start.
REQ-031 busy SHALL be 1 in RESET, RUN, and SCAN.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 halt held at 1 on RUN entry SHALL yield a one-cycle RUN phase.

Reset
REQ-034 rstn=0 SHALL immediately force IDLE and set cpu_rstn=0, cpu_en=0, reg_sel=0, dump_valid=0, dump_data=0, dump_idx=0, dump_last=0, busy=0, done=0, and clear the settle, stop, and mode latches and all counters.
REQ-035 cpu_rstn SHALL return to 1 on the first edge after rstn deasserts.
REQ-036 If rstn asserts mid-scan, any pending beat SHALL be discarded.

Verification
REQ-037 Single shot with defaults, dump_ready=1, start pulse: cpu_rstn low 2 cycles, cpu_en high 10 cycles, then 32 beats with idx 0..31 at 2-cycle spacing; beat 31 has dump_last=1; done=1.
REQ-038 halt rising on RUN cycle 3: cpu_en falls after 3 cycles and scanning begins.
REQ-039 dump_ready low for 5 cycles on beat 7: dump_valid, dump_data, and dump_idx=7 held stable, and reg_sel does not pass 8.
REQ-040 mode_cont=1 session: after beat 31, cpu_en is high 10 cycles again with no cpu_rstn pulse and a second scan follows; stop during the second scan gives DONE after its beat 31.
REQ-041 rstn pulsed low during SCAN at beat 12: outputs match the REQ-034 values immediately, and start is accepted afterwards.
REQ-042 NREG=4, DATA_W=16, RST_CYCLES=1: exactly 4 beats, reg_sel 2 bits wide, dump_last on idx 3.
